// File: rtl/push_stream_tx.sv
// Push-protocol transmit adapter: moves exactly `len` words from a valid/ready
// source into a network input FIFO (data/wr/full), with busy/done/count status.
module push_stream_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr,
    input  logic                  out_full,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  fetched_q, fetched_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;

    logic push;
    logic src_hs;

    // The FIFO has no overflow guard, so the strobe is masked by full combinationally.
    assign push      = buf_valid_q && !out_full;
    assign src_ready = (state_q == RUN) && (fetched_q != len_q) && (!buf_valid_q || !out_full);
    assign src_hs    = src_valid && src_ready;

    assign out_wr   = push;
    assign out_data = buf_data_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign count    = count_q;

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        count_d     = count_q;
        fetched_d   = fetched_q;
        len_d       = len_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = len;
                    count_d     = '0;
                    fetched_d   = '0;
                    buf_valid_d = 1'b0;
                    state_d     = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (push) begin
                    count_d = count_q + ONE;
                    if (count_q == len_q - ONE) state_d = DONE;
                end
                // A reload in the same cycle as a push keeps the buffer full.
                if (src_hs) begin
                    buf_data_d  = src_data;
                    buf_valid_d = 1'b1;
                    fetched_d   = fetched_q + ONE;
                end else if (push) begin
                    buf_valid_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            count_q     <= '0;
            fetched_q   <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            count_q     <= count_d;
            fetched_q   <= fetched_d;
            len_q       <= len_d;
        end
    end

endmodule

// File: tb/tb_push_stream_tx.sv
// Bench for push_stream_tx: directed scenarios plus randomized valid/full traffic,
// checked every cycle against a queue-based model of accepted-but-unpushed words.
module tb_push_stream_tx;

    localparam int DW = 32;
    localparam int LW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] out_data;
    logic          out_wr;
    logic          out_full = 1'b0;
    logic          busy;
    logic          done;
    logic [LW-1:0] count;

    int errs = 0;
    int checks = 0;

    push_stream_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock(clock), .reset(reset), .start(start), .len(len),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .out_data(out_data), .out_wr(out_wr), .out_full(out_full),
        .busy(busy), .done(done), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transfer is "running" until tlen words have been pushed;
    // q holds words accepted upstream and not yet pushed, in acceptance order.
    logic [DW-1:0] q[$];
    int  tlen = 0, acc = 0, pushed = 0;
    bit  run_m = 0, done_due = 0;

    always @(negedge clock) begin
        bit nd;
        bit hs;
        bit wr;
        if (reset) begin
            q.delete();
            tlen = 0; acc = 0; pushed = 0; run_m = 0; done_due = 0;
        end else begin
            chk("out_wr", 64'(out_wr), 64'((q.size() > 0) && !out_full));
            if (out_wr) begin
                if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
                else              chk("wr_empty", 64'(out_wr), 64'(0));
            end
            chk("wr_vs_full", 64'(out_wr && out_full), 64'(0));
            chk("busy", 64'(busy), 64'(run_m));
            chk("done", 64'(done), 64'(done_due));
            chk("count", 64'(count), 64'(pushed));
            chk("src_ready", 64'(src_ready),
                64'(run_m && (acc < tlen) && (q.size() == 0 || !out_full)));

            hs = src_valid && src_ready;
            wr = out_wr;
            nd = 0;
            if (start && !run_m && !done_due) begin
                pushed = 0;
                if (len != 0) begin
                    run_m = 1; tlen = int'(len); acc = 0; q.delete();
                end else begin
                    nd = 1;
                end
            end else if (run_m) begin
                if (hs) begin
                    q.push_back(src_data);
                    acc++;
                end
                if (wr && q.size() > 0) begin
                    void'(q.pop_front());
                    pushed++;
                    if (pushed == tlen) begin
                        run_m = 0;
                        nd = 1;
                    end
                end
            end
            done_due = nd;
        end
    end

    // mode: 0 steady, 1 full stall after 2nd push, 2 toggling valid + ignored start,
    //       3 toggling full, 4 random valid/full/data, 5 async reset after 2nd push
    task automatic run_xfer(input int n, input int mode, input logic [DW-1:0] base);
        int  pushes = 0;
        int  cyc = 0;
        int  fc = 0;
        bit  seen_done = 0;
        bit  hs;
        logic [DW-1:0] word = base;
        @(posedge clock); #1;
        start = 1'b1;
        len = LW'(n);
        src_data = word;
        src_valid = (mode == 4) ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_full = 1'b0;
        while (!seen_done && cyc < 300) begin
            @(negedge clock);
            hs = src_valid && src_ready;
            if (out_wr) pushes++;
            if (done) seen_done = 1;
            if (mode == 5 && pushes == 2) begin
                @(posedge clock); #2;
                reset = 1'b1;
                #1;
                chk("rst_out_wr", 64'(out_wr), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_count", 64'(count), 64'(0));
                chk("rst_src_ready", 64'(src_ready), 64'(0));
                start = 1'b0;
                src_valid = 1'b0;
                @(negedge clock);
                @(posedge clock); #1;
                reset = 1'b0;
                return;
            end
            @(posedge clock); #1;
            cyc++;
            start = 1'b0;
            if (mode == 2 && cyc == 2) begin
                start = 1'b1;
                len = LW'(9);
            end
            if (hs) word = word + 1;
            src_data = (mode == 4) ? $urandom : word;
            case (mode)
                1: begin
                    if (pushes >= 2 && fc < 3) begin out_full = 1'b1; fc++; end
                    else out_full = 1'b0;
                end
                2: src_valid = (cyc % 2 == 0);
                3: out_full = (cyc % 2 == 1);
                4: begin
                    src_valid = ($urandom_range(0, 3) != 0);
                    out_full = ($urandom_range(0, 3) == 0);
                end
                default: ;
            endcase
        end
        chk("timeout_done", 64'(seen_done), 64'(1));
        chk("pushes", 64'(pushes), 64'(n));
        chk("final_count", 64'(count), 64'(n));
        src_valid = 1'b0;
        out_full = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_wr0", 64'(out_wr), 64'(0));
        chk("rst_out_data0", 64'(out_data), 64'(0));
        chk("rst_src_ready0", 64'(src_ready), 64'(0));
        chk("rst_busy0", 64'(busy), 64'(0));
        chk("rst_done0", 64'(done), 64'(0));
        chk("rst_count0", 64'(count), 64'(0));
        reset = 1'b0;

        run_xfer(4, 0, 32'h11);
        run_xfer(6, 1, 32'h20);
        run_xfer(0, 0, 32'h30);
        run_xfer(3, 2, 32'h40);
        run_xfer(8, 5, 32'h50);
        run_xfer(2, 0, 32'h60);
        run_xfer(5, 3, 32'h70);
        run_xfer((1 << LW) - 1, 4, 32'h0);
        run_xfer(1, 3, 32'h90);
        for (int i = 0; i < 10; i++) begin
            run_xfer(int'($urandom_range(0, (1 << LW) - 1)), 4, 32'h0);
        end
        repeat (3) @(posedge clock);
        #1;
        chk("idle_busy", 64'(busy), 64'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/push_stream_tx.md
Name: push_stream_tx

Overview:
- Transmit-side adapter that drives one input-stream port of the multi-dataflow accelerator network using the push protocol (data / wr / full).
- Accepts words from an upstream valid/ready source, such as an HWPE streamer, and pushes exactly a programmed number of words into the network input FIFO.
- One instance per network input stream. It sits between the streamer and the network's inStreamN_data / inStreamN_wr / inStreamN_full pins.
- Provides busy, done and progress status to the controller.

Parameters:
DATA_WIDTH, 32, width of stream words
LEN_WIDTH, 16, width of transfer length and word counter

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a transfer when idle
len  in  LEN_WIDTH  words to push; sampled on accepted start
src_data  in  DATA_WIDTH  upstream word
src_valid  in  1  upstream word valid
src_ready  out  1  upstream word accepted when src_valid && src_ready
out_data  out  DATA_WIDTH  word to network input (to inStreamN_data)
out_wr  out  1  push strobe (to inStreamN_wr)
out_full  in  1  network FIFO full (from inStreamN_full)
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer
count  out  LEN_WIDTH  words pushed in current or last transfer

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. The controller passes the network's clock and reset straight through.
- Reset values: state=IDLE, buf_valid=0, buf_data=0, count=0, fetched=0, len_q=0.
  - Resulting outputs: out_wr=0, out_data=0, src_ready=0, busy=0, done=0.
- State machine: states IDLE, RUN, DONE.
  - IDLE -> RUN on start when len!=0. Latch len_q=len; clear count, fetched and buf_valid.
  - IDLE -> DONE on start when len==0. count is cleared to 0 and nothing is pushed.
  - RUN -> DONE in the cycle after the push that makes count==len_q.
  - DONE -> IDLE unconditionally after 1 cycle.
  - start is ignored in RUN and DONE. len is only sampled on an accepted start.
- Status outputs: busy=1 only in RUN. done=1 only in DONE, which is exactly one cycle.
- Datapath: a one-entry output register (buf_data, buf_valid).
  - out_data = buf_data.
  - out_wr = buf_valid && !out_full, combinational. out_wr must never be 1 while out_full=1, because the FIFO does not guard against writes when full.
  - A push occurs in any cycle where out_wr=1. On a push, count increments.
- Upstream handshake: src_ready = (state==RUN) && (fetched!=len_q) && (!buf_valid || !out_full).
  - src_ready may depend combinationally on out_full.
  - On a src handshake: buf_data<=src_data, buf_valid<=1, fetched increments.
  - If a push and a src handshake occur in the same cycle, the buffer reloads and stays valid, giving 1 word/cycle sustained throughput.
  - If a push occurs with no src handshake, buf_valid<=0.
- Latency: a word accepted at cycle t is presented with out_wr=1 at cycle t+1 if out_full=0 at that time. Otherwise it is held stable until out_full drops.
- Ordering and integrity: words are pushed in acceptance order, with no loss, duplication or reordering.
  - Exactly len_q words are fetched and pushed. src_ready stays 0 once fetched==len_q.
- Counter widths: counters are LEN_WIDTH bits. len = 2^LEN_WIDTH-1 is legal, and no wrap occurs within a transfer.
- After a transfer: count holds its final value until the next accepted start.
- src_valid stalls: gaps on src_valid simply create bubbles on out_wr. State is unaffected.
- Reset mid-transfer: all state is cleared immediately, the buffered word is discarded and out_wr drops asynchronously. Recovering the network FIFO contents is the controller's responsibility.

Test Plan:
1. start, len=4, src_valid=1 carrying 0x11,0x12,0x13,0x14, out_full=0 -> out_wr high for 4 consecutive cycles starting one cycle after the first src handshake; out_data 0x11..0x14 in order; done pulses the cycle after the last push; count=4; busy falls with done.
2. len=6, out_full forced high for 3 cycles after the 2nd push -> out_wr=0 and src_ready=0 during the stall with out_data held; all 6 words delivered once, in order; count=6.
3. start with len=0 -> done=1 in the next cycle, busy never asserted, no out_wr, count=0.
4. len=3, src_valid toggling 1,0,1,0,1 -> exactly 3 pushes with bubbles; second start with len=9 issued during RUN is ignored (total pushes=3).
5. len=8, assert reset asynchronously mid-cycle after the 2nd push -> out_wr, busy and count go 0 immediately; after release, start len=2 completes normally with count=2.
6. len=5, out_full toggling every cycle -> out_wr is never high while out_full is high; 5 pushes total, correct order.
